// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared screen-state, colour and VGA geometry definitions
package maze_pkg;

  typedef enum logic [2:0] {
    BANNER    = 3'd0,
    PLAY      = 3'd1,
    GAME_OVER = 3'd2,
    WIN       = 3'd3
  } screen_state_t;

  localparam logic [7:0] COL_BG_DEF     = 8'h00;
  localparam logic [7:0] COL_WALL_DEF   = 8'h03;
  localparam logic [7:0] COL_PLAYER_DEF = 8'hE0;
  localparam logic [7:0] COL_GOAL_DEF   = 8'h1C;
  localparam logic [7:0] COL_TEXT_DEF   = 8'hFF;

  localparam int         H_ACTIVE    = 640;
  localparam int         V_ACTIVE    = 480;
  localparam logic [9:0] VTICK_Y_DEF = 10'd480;

endpackage

// File: rtl/screen_compositor_if.sv
// rtl/screen_compositor_if.sv - pixel, event and status signals of the compositor
interface screen_compositor_if;
  logic [9:0] xCount;
  logic [9:0] yCount;
  logic       video_on;
  logic       game_over_text;
  logic       win_text;
  logic       level_text;
  logic       level_num1_text;
  logic       level_num2_text;
  logic       wall_px;
  logic       player_px;
  logic       goal_px;
  logic       hit_wall;
  logic       reached_goal;
  logic       start;
  logic [7:0] rgb;
  logic [1:0] level;
  logic       freeze;
  logic [2:0] screen_state;

  modport master (
    output xCount, yCount, video_on,
    output game_over_text, win_text, level_text, level_num1_text, level_num2_text,
    output wall_px, player_px, goal_px,
    output hit_wall, reached_goal, start,
    input  rgb, level, freeze, screen_state
  );

  modport slave (
    input  xCount, yCount, video_on,
    input  game_over_text, win_text, level_text, level_num1_text, level_num2_text,
    input  wall_px, player_px, goal_px,
    input  hit_wall, reached_goal, start,
    output rgb, level, freeze, screen_state
  );
endinterface

// File: rtl/screen_fsm.sv
// rtl/screen_fsm.sv - game-screen state machine with level register and banner frame counter
module screen_fsm
  import maze_pkg::*;
#(
  parameter int BANNER_FRAMES = 120
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_tick,
  input  logic          hit_wall,
  input  logic          reached_goal,
  input  logic          start,
  output screen_state_t state,
  output logic [1:0]    level,
  output logic          freeze
);

  localparam int              CNT_W = (BANNER_FRAMES > 1) ? $clog2(BANNER_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BANNER_FRAMES - 1);

  logic [CNT_W-1:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BANNER;
      level     <= 2'd1;
      frame_cnt <= '0;
      freeze    <= 1'b1;
    end else begin
      case (state)
        BANNER: begin
          if (frame_tick) begin
            if (frame_cnt == LAST) begin
              frame_cnt <= '0;
              state     <= PLAY;
              freeze    <= 1'b0;
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end
        end
        PLAY: begin
          // a wall collision outranks a simultaneous goal
          if (hit_wall) begin
            state  <= GAME_OVER;
            freeze <= 1'b1;
          end else if (reached_goal) begin
            freeze    <= 1'b1;
            frame_cnt <= '0;
            if (level == 2'd1) begin
              level <= 2'd2;
              state <= BANNER;
            end else begin
              state <= WIN;
            end
          end
        end
        GAME_OVER, WIN: begin
          if (start) begin
            level     <= 2'd1;
            frame_cnt <= '0;
            state     <= BANNER;
            freeze    <= 1'b1;
          end
        end
        default: begin
          state  <= BANNER;
          freeze <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/screen_compositor.sv
// rtl/screen_compositor.sv - aligns maze flags to text flags and muxes the final RGB 3-3-2 pixel
module screen_compositor
  import maze_pkg::*;
#(
  parameter int         BANNER_FRAMES = 120,
  parameter logic [9:0] VTICK_Y       = VTICK_Y_DEF,
  parameter logic [7:0] COL_BG        = COL_BG_DEF,
  parameter logic [7:0] COL_WALL      = COL_WALL_DEF,
  parameter logic [7:0] COL_PLAYER    = COL_PLAYER_DEF,
  parameter logic [7:0] COL_GOAL      = COL_GOAL_DEF,
  parameter logic [7:0] COL_TEXT      = COL_TEXT_DEF
) (
  input logic          clk,
  input logic          rst,
  screen_compositor_if.slave bus
);

  screen_state_t state;
  logic [1:0]    level;
  logic          freeze;
  logic          frame_tick;

  logic          video_on_d;
  logic          wall_d;
  logic          player_d;
  logic          goal_d;
  logic          level_shown;
  logic [7:0]    pix_col;
  logic [7:0]    rgb_q;

  assign frame_tick = (bus.xCount == 10'd0) && (bus.yCount == VTICK_Y);

  screen_fsm #(
    .BANNER_FRAMES(BANNER_FRAMES)
  ) u_fsm (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .hit_wall     (bus.hit_wall),
    .reached_goal (bus.reached_goal),
    .start        (bus.start),
    .state        (state),
    .level        (level),
    .freeze       (freeze)
  );

  // Stage 1: delay same-cycle flags to meet the one-cycle text flags
  always_ff @(posedge clk) begin
    if (rst) begin
      video_on_d <= 1'b0;
      wall_d     <= 1'b0;
      player_d   <= 1'b0;
      goal_d     <= 1'b0;
    end else begin
      video_on_d <= bus.video_on;
      wall_d     <= bus.wall_px;
      player_d   <= bus.player_px;
      goal_d     <= bus.goal_px;
    end
  end

  assign level_shown = bus.level_text |
                       ((level == 2'd2) ? bus.level_num2_text : bus.level_num1_text);

  always_comb begin
    pix_col = COL_BG;
    case (state)
      BANNER: begin
        if (level_shown) pix_col = COL_TEXT;
      end
      PLAY: begin
        if (level_shown)   pix_col = COL_TEXT;
        else if (player_d) pix_col = COL_PLAYER;
        else if (goal_d)   pix_col = COL_GOAL;
        else if (wall_d)   pix_col = COL_WALL;
      end
      GAME_OVER: begin
        if (bus.game_over_text) pix_col = COL_TEXT;
        else if (wall_d)        pix_col = COL_WALL;
      end
      WIN: begin
        if (bus.win_text) pix_col = COL_TEXT;
      end
      default: pix_col = COL_BG;
    endcase
    if (!video_on_d) pix_col = 8'h00;
  end

  // Stage 2
  always_ff @(posedge clk) begin
    if (rst) rgb_q <= 8'h00;
    else     rgb_q <= pix_col;
  end

  assign bus.rgb          = rgb_q;
  assign bus.level        = level;
  assign bus.freeze       = freeze;
  assign bus.screen_state = state;

endmodule

// File: doc/screen_compositor.md
Name: screen_compositor

Overview:
- Final pixel stage of the maze display path. Sits downstream of the text overlay generator and the maze/player renderers, and upstream of the VGA DAC pins.
- Owns the game-screen state machine (level banner, play, win, game over), which selects the text layer to show.
- Merges the text, wall, player and goal flags into one registered RGB pixel, aligned to the one-cycle-registered text flags.

Parameters:
- BANNER_FRAMES, 120, frames the "LEVEL n" banner is held before play starts (2 s at 60 Hz)
- VTICK_Y, 480, yCount value whose xCount==0 pixel generates the frame tick (start of vertical blank)
- COL_BG, 8'h00, background colour (RGB 3-3-2)
- COL_WALL, 8'h03, wall colour
- COL_PLAYER, 8'hE0, player colour
- COL_GOAL, 8'h1C, goal colour
- COL_TEXT, 8'hFF, text colour

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- xCount  in  10  current pixel column from the sync generator
- yCount  in  10  current pixel row from the sync generator
- video_on  in  1  active-display flag, same cycle as xCount/yCount
- game_over_text  in  1  text flag, valid one cycle after xCount/yCount
- win_text  in  1  text flag, one-cycle latency
- level_text  in  1  "LEVEL" flag, one-cycle latency
- level_num1_text  in  1  digit "1" flag, one-cycle latency
- level_num2_text  in  1  digit "2" flag, one-cycle latency
- wall_px  in  1  maze wall at current pixel, same cycle as xCount
- player_px  in  1  player sprite at current pixel, same cycle
- goal_px  in  1  goal tile at current pixel, same cycle
- hit_wall  in  1  one-cycle pulse: player collided with a wall
- reached_goal  in  1  one-cycle pulse: player reached the goal
- start  in  1  one-cycle pulse: restart request (debounced button)
- rgb  out  8  composited pixel, RGB 3-3-2
- level  out  2  current level, 1 or 2
- freeze  out  1  1 = player movement is disabled
- screen_state  out  3  current FSM state, for LEDs and debug

Behaviour:
- Reset values: FSM enters BANNER; level=1; frame counter=0; rgb=8'h00; freeze=1; all pipeline registers 0.
- Pipeline alignment:
  - Stage 1 registers video_on, wall_px, player_px and goal_px, so they line up with the text flags.
  - Stage 2 registers rgb.
  - Total latency from xCount/yCount to rgb is 2 clk.
- Frame tick: single-cycle pulse when xCount==0 and yCount==VTICK_Y, evaluated on the undelayed inputs.
- FSM states: BANNER, PLAY, GAME_OVER, WIN.
- BANNER:
  - freeze=1.
  - Frame counter increments on each frame tick.
  - When the counter reaches BANNER_FRAMES-1 on a tick, it clears and the FSM moves to PLAY.
- PLAY:
  - freeze=0.
  - hit_wall moves to GAME_OVER.
  - reached_goal with level==1 sets level=2 and moves to BANNER; the counter is cleared.
  - reached_goal with level==2 moves to WIN.
  - If hit_wall and reached_goal arrive in the same cycle, hit_wall wins.
- GAME_OVER / WIN:
  - freeze=1.
  - start sets level=1, clears the counter and moves to BANNER.
- start is ignored in BANNER and PLAY. hit_wall and reached_goal are ignored outside PLAY.
- Composition priority (stage-1 values): if the delayed video_on is 0, rgb=8'h00. Otherwise the colour is chosen per state:
  - BANNER: (level_text or the digit matching level) gives COL_TEXT, else COL_BG. Maze is hidden.
  - PLAY: text (level_text or matching digit) > player > goal > wall > background.
  - GAME_OVER: game_over_text gives COL_TEXT, otherwise wall gives COL_WALL, else COL_BG.
  - WIN: win_text gives COL_TEXT, else COL_BG.
- Digit selection: level==1 uses level_num1_text only; level==2 uses level_num2_text only.
- State and level change on a clock edge take effect in the composition on the next pixel. Mid-frame changes are allowed, and no tearing protection is required.
- rst mid-frame: all outputs return to their reset values on the next edge. rgb is black until two pixels after rst deasserts.

Decomposition:
- Shared package maze_pkg holds:
  - the screen-state enum (BANNER=0, PLAY=1, GAME_OVER=2, WIN=3, 3-bit encoding)
  - the colour constants
  - the VGA geometry constants (640x480, VTICK_Y)
- One sub-module, screen_fsm, contains the state machine, level register and frame counter. It takes the frame tick, hit_wall, reached_goal and start, and returns state, level and freeze.
- The top level keeps the alignment registers and the colour mux.

Test Plan:
- Reset with BANNER_FRAMES=2: screen_state=BANNER, level=1, freeze=1. After 2 frame ticks -> PLAY, freeze=0. Pixel (100,100) with video_on=1, wall_px=1 gives rgb=8'h03 exactly 2 clk later.
- In PLAY, pulse hit_wall and reached_goal in the same cycle -> GAME_OVER, level stays 1. game_over_text=1 gives rgb=8'hFF. Pulse start -> BANNER, level=1.
- In PLAY level 1, pulse reached_goal -> BANNER, level=2. level_num1_text=1 gives rgb=8'h00; level_num2_text=1 gives rgb=8'hFF.
- In PLAY level 2, pulse reached_goal -> WIN. hit_wall is then ignored and the state stays WIN. win_text=1 gives rgb=8'hFF.
- Overlap in PLAY: player_px=1, wall_px=1, goal_px=1 gives rgb=8'hE0. With video_on=0 and the same flags, rgb=8'h00.
- Assert rst during PLAY mid-line -> next edge: rgb=0, BANNER, level=1, freeze=1. The frame counter restarts from 0.
